// File: rtl/grid_pkg.sv
// Shared encodings for the board cursor and the ship-placement controller.
package grid_pkg;

  // Direction codes carried alongside a step strobe
  localparam logic [1:0] DIR_L = 2'd0;
  localparam logic [1:0] DIR_R = 2'd1;
  localparam logic [1:0] DIR_D = 2'd2;
  localparam logic [1:0] DIR_U = 2'd3;

  // Auto-repeat FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  // Debounced direction button levels
  typedef struct packed {
    logic left;
    logic right;
    logic down;
    logic up;
  } btn_t;

endpackage

// File: rtl/hold_repeater.sv
// Press-edge detection, direction priority and hold-to-auto-repeat timing.
module hold_repeater
  import grid_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  btn_t       btn_i,
  input  logic       clr_i,
  output logic       step_c,
  output logic [1:0] dir_c
);

  localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  rpt_state_e       state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       prev_q;
  logic [3:0]       btn_v;
  logic [3:0]       rise;
  logic             held;

  assign btn_v = {btn_i.left, btn_i.right, btn_i.down, btn_i.up};
  assign rise  = btn_v & ~prev_q;

  // Level of the button that owns the current hold
  always_comb begin
    case (dir_q)
      DIR_L:   held = btn_i.left;
      DIR_R:   held = btn_i.right;
      DIR_D:   held = btn_i.down;
      default: held = btn_i.up;
    endcase
  end

  // Next-state, timer and step strobe
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    tmr_d   = tmr_q;
    step_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|rise) begin
          step_c  = 1'b1;
          state_d = ST_DELAY;
          tmr_d   = '0;
          if (rise[3])      dir_d = DIR_L;
          else if (rise[2]) dir_d = DIR_R;
          else if (rise[1]) dir_d = DIR_D;
          else              dir_d = DIR_U;
        end
      end
      ST_DELAY: begin
        if (!held) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(REPEAT_DELAY - 1)) begin
          step_c  = 1'b1;
          state_d = ST_REPEAT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!held) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(REPEAT_RATE - 1)) begin
          step_c = 1'b1;
          tmr_d  = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A jump abandons the hold; the held button must be pressed again
    if (clr_i) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
    end
    dir_c = dir_d;
  end

  // State, timer and previous-level registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_L;
      tmr_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tmr_q   <= tmr_d;
      prev_q  <= btn_v;
    end
  end

endmodule

// File: rtl/grid_cursor.sv
// Cursor position on a COLS x ROWS grid with clamp/wrap edges, load and move strobe.
module grid_cursor
  import grid_pkg::*;
#(
  parameter int unsigned COLS         = 10,
  parameter int unsigned ROWS         = 10,
  parameter bit          WRAP         = 1'b0,
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000,
  parameter int unsigned IDX_W        = $clog2(COLS * ROWS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    left,
  input  logic                    right,
  input  logic                    up,
  input  logic                    down,
  input  logic                    load,
  input  logic [IDX_W-1:0]        load_idx,
  output logic [$clog2(COLS)-1:0] col,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [IDX_W-1:0]        idx,
  output logic                    moved
);

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned CELLS = COLS * ROWS;

  logic [COL_W-1:0] col_q, col_d, load_col;
  logic [ROW_W-1:0] row_q, row_d, load_row;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             moved_q, moved_d;
  logic             load_ok;
  logic             step;
  logic [1:0]       dir;
  btn_t             btn;

  assign btn      = {left, right, down, up};
  assign load_ok  = load && (32'(load_idx) < CELLS);
  assign load_col = COL_W'(32'(load_idx) % COLS);
  assign load_row = ROW_W'(32'(load_idx) / COLS);

  hold_repeater #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_rep (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn),
    .clr_i  (load_ok),
    .step_c (step),
    .dir_c  (dir)
  );

  // Next position: load wins over a step; steps clamp or wrap at edges
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (load_ok) begin
      col_d = load_col;
      row_d = load_row;
    end else if (step) begin
      case (dir)
        DIR_L: begin
          if (col_q != '0) col_d = col_q - COL_W'(1);
          else if (WRAP)   col_d = COL_W'(COLS - 1);
        end
        DIR_R: begin
          if (col_q != COL_W'(COLS - 1)) col_d = col_q + COL_W'(1);
          else if (WRAP)                 col_d = '0;
        end
        DIR_D: begin
          if (row_q != ROW_W'(ROWS - 1)) row_d = row_q + ROW_W'(1);
          else if (WRAP)                 row_d = '0;
        end
        default: begin
          if (row_q != '0) row_d = row_q - ROW_W'(1);
          else if (WRAP)   row_d = ROW_W'(ROWS - 1);
        end
      endcase
    end
    idx_d   = IDX_W'(row_d) * IDX_W'(COLS) + IDX_W'(col_d);
    moved_d = (col_d != col_q) || (row_d != row_q);
  end

  // Position, index and move-strobe registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      moved_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      moved_q <= moved_d;
    end
  end

  assign col   = col_q;
  assign row   = row_q;
  assign idx   = idx_q;
  assign moved = moved_q;

endmodule

// File: tb/tb_grid_cursor.sv
// Self-checking bench for grid_cursor: one clamp instance and one wrap instance.
module tb_grid_cursor;

  localparam int unsigned COLS = 10;
  localparam int unsigned ROWS = 10;
  localparam int unsigned IW   = 7;
  localparam int unsigned CW   = 4;
  localparam int unsigned RW   = 4;

  // button vector {left, right, up, down, load}
  localparam logic [4:0] B_N  = 5'b00000;
  localparam logic [4:0] B_L  = 5'b10000;
  localparam logic [4:0] B_R  = 5'b01000;
  localparam logic [4:0] B_U  = 5'b00100;
  localparam logic [4:0] B_D  = 5'b00010;
  localparam logic [4:0] B_LD = 5'b00001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]    c_btn = B_N;
  logic [4:0]    w_btn = B_N;
  logic [IW-1:0] c_li  = '0;
  logic [IW-1:0] w_li  = '0;
  logic [CW-1:0] c_col, w_col;
  logic [RW-1:0] c_row, w_row;
  logic [IW-1:0] c_idx, w_idx;
  logic          c_moved, w_moved;

  grid_cursor #(
    .COLS(COLS), .ROWS(ROWS), .WRAP(1'b0), .REPEAT_DELAY(8), .REPEAT_RATE(3)
  ) dut_c (
    .clk(clk), .rst_n(rst_n),
    .left(c_btn[4]), .right(c_btn[3]), .up(c_btn[2]), .down(c_btn[1]),
    .load(c_btn[0]), .load_idx(c_li),
    .col(c_col), .row(c_row), .idx(c_idx), .moved(c_moved)
  );

  grid_cursor #(
    .COLS(COLS), .ROWS(ROWS), .WRAP(1'b1), .REPEAT_DELAY(8), .REPEAT_RATE(3)
  ) dut_w (
    .clk(clk), .rst_n(rst_n),
    .left(w_btn[4]), .right(w_btn[3]), .up(w_btn[2]), .down(w_btn[1]),
    .load(w_btn[0]), .load_idx(w_li),
    .col(w_col), .row(w_row), .idx(w_idx), .moved(w_moved)
  );

  typedef struct packed {
    logic          w;
    logic [4:0]    btn;
    logic [IW-1:0] li;
    logic [CW-1:0] c;
    logic [RW-1:0] r;
    logic [IW-1:0] i;
    logic          m;
  } vec_t;

  vec_t  vecs[$];
  vec_t  sb[$];
  string nm_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  function automatic vec_t mk(input logic w, input logic [4:0] b, input int li,
                              input int c, input int r, input logic m);
    vec_t v;
    v.w   = w;
    v.btn = b;
    v.li  = IW'(li);
    v.c   = CW'(c);
    v.r   = RW'(r);
    v.i   = IW'(r * COLS + c);
    v.m   = m;
    return v;
  endfunction

  task automatic add(input logic w, input logic [4:0] b, input int li,
                     input int c, input int r, input logic m);
    vecs.push_back(mk(w, b, li, c, r, m));
  endtask

  task automatic check_out();
    vec_t          e;
    string         nm;
    logic [CW-1:0] ac;
    logic [RW-1:0] ar;
    logic [IW-1:0] ai;
    logic          am;
    e  = sb.pop_front();
    nm = nm_q.pop_front();
    if (e.w) begin
      ac = w_col; ar = w_row; ai = w_idx; am = w_moved;
    end else begin
      ac = c_col; ar = c_row; ai = c_idx; am = c_moved;
    end
    n_chk++;
    if (ac === e.c && ar === e.r && ai === e.i && am === e.m) n_pass++;
    else $display("FAIL %s (%s): got col=%0d row=%0d idx=%0d moved=%0d, want col=%0d row=%0d idx=%0d moved=%0d",
                  nm, e.w ? "wrap" : "clamp", ac, ar, ai, am, e.c, e.r, e.i, e.m);
  endtask

  // Apply one cycle of stimulus to the selected DUT and score its response
  task automatic drive(input vec_t v, input string nm);
    if (v.w) begin
      w_btn = v.btn; w_li = v.li; c_btn = B_N; c_li = '0;
    end else begin
      c_btn = v.btn; c_li = v.li; w_btn = B_N; w_li = '0;
    end
    sb.push_back(v);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // reset state of both instances
    rst_n = 1'b0;
    drive(mk(0, B_N, 0, 0, 0, 0), "rst_clamp");
    drive(mk(1, B_N, 0, 0, 0, 0), "rst_wrap");
    rst_n = 1'b1;

    // clamp instance: first press, walls, column of downs
    add(0, B_R, 0, 1, 0, 1);  add(0, B_N, 0, 1, 0, 0);
    add(0, B_L, 0, 0, 0, 1);  add(0, B_N, 0, 0, 0, 0);
    add(0, B_L, 0, 0, 0, 0);  add(0, B_N, 0, 0, 0, 0);
    add(0, B_U, 0, 0, 0, 0);  add(0, B_N, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      add(0, B_D, 0, 0, k, 1); add(0, B_N, 0, 0, k, 0);
    end
    add(0, B_D, 0, 0, 9, 0);  add(0, B_N, 0, 0, 9, 0);
    // simultaneous left+right at col 4
    for (int k = 1; k <= 4; k++) begin
      add(0, B_R, 0, k, 9, 1); add(0, B_N, 0, k, 9, 0);
    end
    add(0, B_L | B_R, 0, 3, 9, 1); add(0, B_N, 0, 3, 9, 0);
    // load while right is held, then no repeat until re-press
    add(0, B_R, 0, 4, 9, 1);
    add(0, B_R | B_LD, 57, 7, 5, 1);
    for (int k = 0; k < 12; k++) add(0, B_R, 0, 7, 5, 0);
    add(0, B_N, 0, 7, 5, 0);
    add(0, B_R, 0, 8, 5, 1);  add(0, B_N, 0, 8, 5, 0);
    add(0, B_LD, 100, 8, 5, 0); add(0, B_N, 0, 8, 5, 0);
    add(0, B_LD, 99, 9, 9, 1);  add(0, B_N, 0, 9, 9, 0);
    add(0, B_R, 0, 9, 9, 0);  add(0, B_N, 0, 9, 9, 0);
    add(0, B_D, 0, 9, 9, 0);  add(0, B_N, 0, 9, 9, 0);
    add(0, B_LD, 0, 0, 0, 1); add(0, B_N, 0, 0, 0, 0);
    // wrap instance: edges in both axes
    for (int k = 1; k <= 3; k++) begin
      add(1, B_D, 0, 0, k, 1); add(1, B_N, 0, 0, k, 0);
    end
    add(1, B_L, 0, 9, 3, 1);  add(1, B_N, 0, 9, 3, 0);
    add(1, B_R, 0, 0, 3, 1);  add(1, B_N, 0, 0, 3, 0);
    add(1, B_LD, 93, 3, 9, 1); add(1, B_N, 0, 3, 9, 0);
    add(1, B_D, 0, 3, 0, 1);  add(1, B_N, 0, 3, 0, 0);
    add(1, B_U, 0, 3, 9, 1);  add(1, B_N, 0, 3, 9, 0);

    for (int k = 0; k < vecs.size(); k++) drive(vecs[k], $sformatf("vec%0d", k));

    // auto-repeat: steps at press, +8, +11, +14, +17
    for (int i = 0; i < 20; i++) begin
      int c;
      c = 1 + int'(i >= 8) + int'(i >= 11) + int'(i >= 14) + int'(i >= 17);
      drive(mk(0, B_R, 0, c, 0, (i == 0 || i == 8 || i == 11 || i == 14 || i == 17)), "rpt_hold");
    end
    for (int i = 0; i < 6; i++) drive(mk(0, B_N, 0, 5, 0, 0), "rpt_release");

    // reset while in REPEAT with right held
    for (int i = 0; i < 10; i++)
      drive(mk(0, B_R, 0, (i >= 8) ? 7 : 6, 0, (i == 0 || i == 8)), "mid_hold");
    rst_n = 1'b0;
    drive(mk(0, B_R, 0, 0, 0, 0), "mid_rst");
    drive(mk(0, B_R, 0, 0, 0, 0), "mid_rst");
    rst_n = 1'b1;
    drive(mk(0, B_R, 0, 1, 0, 1), "post_rst_edge");
    for (int i = 0; i < 6; i++) drive(mk(0, B_R, 0, 1, 0, 0), "post_rst_hold");
    for (int i = 0; i < 3; i++) drive(mk(0, B_N, 0, 1, 0, 0), "post_rst_release");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/grid_cursor.md
Name: grid_cursor

Overview:
- Parametrised successor to the 10x10 board cursor: it tracks a cursor on a COLS x ROWS grid and outputs row, column and linear index.
- Adds wrap/clamp mode, hold-to-auto-repeat, direct coordinate load and a move strobe.
- Sits between the debounced direction buttons and the board RAM/VGA overlay. The linear index addresses board memory; row and col drive the highlight renderer.

Parameters:
- COLS, 10, grid columns (2..64)
- ROWS, 10, grid rows (2..64)
- WRAP, 0, 0 = clamp at edges; 1 = toroidal wrap within the current row/column
- REPEAT_DELAY, 50_000_000, cycles a direction is held before the first auto-repeat step
- REPEAT_RATE, 10_000_000, cycles between subsequent auto-repeat steps
- IDX_W, $clog2(COLS*ROWS), linear index width (derived)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- left  in  1  level, debounced; col-1
- right  in  1  level, debounced; col+1
- up  in  1  level, debounced; row-1
- down  in  1  level, debounced; row+1
- load  in  1  single-cycle request to jump to load_idx
- load_idx  in  IDX_W  target linear index
- col  out  $clog2(COLS)  current column
- row  out  $clog2(ROWS)  current row
- idx  out  IDX_W  row*COLS+col, registered
- moved  out  1  one-cycle pulse, high in the cycle after any position change

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. With rst_n=0 at a clk edge: col=0, row=0, idx=0, moved=0, repeat FSM=IDLE, timer=0. The registered previous-button levels are cleared to 0, so a button held through reset produces a press edge after release of reset.
- Step priority in one cycle: load > left > right > down > up. Exactly one step per cycle maximum.
- load: when load_idx < COLS*ROWS, set col=load_idx%COLS and row=load_idx/COLS next cycle, and assert moved. An out-of-range load is ignored: no change, no moved, FSM unaffected. A valid load forces the FSM to IDLE; the held direction re-arms only on a new press edge.
- Repeat FSM states: IDLE, DELAY, REPEAT. The active direction register dir holds one of L/R/D/U.
  - IDLE: a rising edge on any direction (highest priority if several) issues one step and latches dir. The timer is cleared and the FSM goes to DELAY.
  - DELAY: if the dir input drops, go to IDLE. If the timer reaches REPEAT_DELAY-1, step, clear the timer and go to REPEAT.
  - REPEAT: if dir drops, go to IDLE. Every REPEAT_RATE cycles, step.
  - Other buttons pressed while in DELAY or REPEAT are ignored until dir releases and the FSM returns to IDLE.
- Edges: col/row/idx/moved update on the edge after the press edge is sampled, i.e. one-cycle latency from the input change.
- Boundaries, WRAP=0: a step off an edge is a no-op (no moved). The FSM keeps timing, so holding against a wall yields no output activity.
- Boundaries, WRAP=1:
  - left at col 0 -> col=COLS-1; right at COLS-1 -> 0 (same row)
  - up at row 0 -> ROWS-1; down at ROWS-1 -> 0 (same column)
- idx is always consistent with the same-cycle row/col. The multiply is by a constant; no divider is inferred except on the load path, which uses a constant divide/modulo.
- moved=1 only when the new position differs from the old one. For a 1-wide wrap this is impossible because COLS/ROWS >= 2.

Decomposition:
- Package grid_pkg: direction encoding localparams (DIR_L=0, DIR_R=1, DIR_D=2, DIR_U=3) and the FSM state encoding (ST_IDLE, ST_DELAY, ST_REPEAT), shared with the ship-placement controller.
- Sub-module hold_repeater: edge detect, priority select, timer and FSM. It emits a one-cycle step strobe plus a 2-bit dir code.
- grid_cursor keeps the position registers, the wrap/clamp arithmetic, the load path and moved.

Test Plan:
- Reset and press: with rst_n=0 for 2 cycles then released, pulse right for 1 cycle -> col=1, row=0, idx=1, moved high for exactly 1 cycle, one cycle after the press.
- Clamp: WRAP=0, position (0,0), press left and up -> no change, moved never asserts. Press down 9 times at COLS=ROWS=10 -> row=9, idx=90; a 10th down -> still 90.
- Wrap: WRAP=1, col=0 row=3, press left -> col=9 row=3 idx=39. From row=9 press down -> row=0.
- Auto-repeat: with REPEAT_DELAY=8 and REPEAT_RATE=3, hold right for 20 cycles from (0,0). Steps occur at the press edge, then at +8, +11, +14, +17 -> col=5. Release -> FSM IDLE, no further steps.
- Simultaneous and load: left+right rising on the same cycle at col=4 -> col=3. load=1 with load_idx=57 while right is held -> row=5, col=7, FSM IDLE, no repeat until right is re-pressed. Then load_idx=100 -> ignored.
- Reset mid-operation: rst_n=0 during REPEAT with right still held -> outputs 0, FSM IDLE. After rst_n returns to 1, the held right produces exactly one step, from the press edge.
